// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory bus arbiter.
// Holds requester ids, the request record and the grant-priority helper.
package mem_bus_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF      = 32;
  localparam int DATA_WIDTH_DEF      = 32;
  localparam int MAX_OUTSTANDING_DEF = 4;
  localparam int STARVE_LIMIT_DEF    = 8;

  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } req_id_e;

  typedef struct packed {
    logic                        wr;
    logic [DATA_WIDTH_DEF/8-1:0] wstrb;
    logic [ADDR_WIDTH_DEF-1:0]   addr;
    logic [DATA_WIDTH_DEF-1:0]   wdata;
  } mem_req_t;

  // Data normally wins; a starved fetch overrides it.
  function automatic req_id_e pick_winner(input logic inst_req,
                                          input logic data_req,
                                          input logic inst_starved);
    req_id_e winner;
    if (data_req && !(inst_req && inst_starved)) begin
      winner = REQ_DATA;
    end else begin
      winner = REQ_INST;
    end
    return winner;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_order_fifo.sv
// Issue-order FIFO of requester ids; its head names the owner of the next
// bus response.
module order_fifo
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_id_e            mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               full_s;
  logic               empty_s;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push & ~full_s;
  assign pop_ok_s  = pop & ~empty_s;

  // Pointer and occupancy tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Id storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= req_id_e'(push_id);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access,
// routing each in-order response back to the requester that issued it.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int STARVE_LIMIT    = STARVE_LIMIT_DEF
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               inst_req,
  input  logic [ADDR_WIDTH-1:0]              inst_addr,
  output logic                               inst_addr_ok,
  output logic                               inst_data_ok,
  output logic [DATA_WIDTH-1:0]              inst_rdata,
  input  logic                               data_req,
  input  logic                               data_wr,
  input  logic [DATA_WIDTH/8-1:0]            data_wstrb,
  input  logic [ADDR_WIDTH-1:0]              data_addr,
  input  logic [DATA_WIDTH-1:0]              data_wdata,
  output logic                               data_addr_ok,
  output logic                               data_data_ok,
  output logic [DATA_WIDTH-1:0]              data_rdata,
  output logic                               bus_req,
  output logic                               bus_wr,
  output logic [DATA_WIDTH/8-1:0]            bus_wstrb,
  output logic [ADDR_WIDTH-1:0]              bus_addr,
  output logic [DATA_WIDTH-1:0]              bus_wdata,
  input  logic                               bus_addr_ok,
  input  logic                               bus_data_ok,
  input  logic [DATA_WIDTH-1:0]              bus_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_count,
  output logic                               protocol_error
);

  localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic                    wr;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
  } bus_fields_t;

  logic                lock_r;
  req_id_e             lock_id_r;
  logic [STARVE_W-1:0] starve_r;
  logic                protocol_error_r;

  req_id_e             grant_s;
  bus_fields_t         grant_fields_s;
  logic                bus_req_s;
  logic                accept_s;
  logic                pop_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                fifo_head_s;
  logic [CNT_W-1:0]    fifo_count_s;

  assign bus_req_s = ~reset & (inst_req | data_req) & ~fifo_full_s;
  assign accept_s  = bus_req_s & bus_addr_ok;
  assign pop_s     = ~reset & bus_data_ok & ~fifo_empty_s;

  // Grant selection; a held lock keeps the bus stable across a stalled handshake.
  always_comb begin
    grant_s = REQ_INST;
    if (lock_r) begin
      grant_s = lock_id_r;
    end else begin
      grant_s = pick_winner(inst_req, data_req,
                            starve_r == STARVE_W'(STARVE_LIMIT));
    end
  end

  // Downstream field mux; fetches are always plain reads.
  always_comb begin
    grant_fields_s = '0;
    case (grant_s)
      REQ_DATA: begin
        grant_fields_s.wr    = data_wr;
        grant_fields_s.wstrb = data_wstrb;
        grant_fields_s.addr  = data_addr;
        grant_fields_s.wdata = data_wdata;
      end
      REQ_INST: begin
        grant_fields_s.addr  = inst_addr;
      end
      default: grant_fields_s = '0;
    endcase
  end

  // Lock capture on a stalled request, released by the accepting addr_ok.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_r    <= 1'b0;
      lock_id_r <= REQ_INST;
    end else if (accept_s) begin
      lock_r    <= 1'b0;
      lock_id_r <= lock_id_r;
    end else if (bus_req_s) begin
      lock_r    <= 1'b1;
      lock_id_r <= grant_s;
    end else begin
      lock_r    <= lock_r;
      lock_id_r <= lock_id_r;
    end
  end

  // Count data wins over a waiting fetch; saturate so the override holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_r <= {STARVE_W{1'b0}};
    end else if (accept_s && grant_s == REQ_INST) begin
      starve_r <= {STARVE_W{1'b0}};
    end else if (accept_s && inst_req && starve_r != STARVE_W'(STARVE_LIMIT)) begin
      starve_r <= starve_r + STARVE_W'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

  // Sticky flag for a response nobody asked for.
  always_ff @(posedge clock) begin
    if (reset) begin
      protocol_error_r <= 1'b0;
    end else if (bus_data_ok && fifo_empty_s) begin
      protocol_error_r <= 1'b1;
    end else begin
      protocol_error_r <= protocol_error_r;
    end
  end

  order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (accept_s),
    .push_id (grant_s),
    .pop     (pop_s),
    .head    (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign bus_req           = bus_req_s;
  assign bus_wr            = grant_fields_s.wr;
  assign bus_wstrb         = grant_fields_s.wstrb;
  assign bus_addr          = grant_fields_s.addr;
  assign bus_wdata         = grant_fields_s.wdata;
  assign inst_addr_ok      = accept_s & (grant_s == REQ_INST);
  assign data_addr_ok      = accept_s & (grant_s == REQ_DATA);
  assign inst_data_ok      = pop_s & (fifo_head_s == REQ_INST);
  assign data_data_ok      = pop_s & (fifo_head_s == REQ_DATA);
  assign inst_rdata        = bus_rdata;
  assign data_rdata        = bus_rdata;
  assign outstanding_count = fifo_count_s;
  assign protocol_error    = protocol_error_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, contention, starvation, lock,
// full FIFO and stray-response cases with hand-computed expectations.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic [2:0]  outstanding_count;
  logic        protocol_error;

  int compared   = 0;
  int mismatched = 0;

  mem_bus_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_addr_ok      (inst_addr_ok),
    .inst_data_ok      (inst_data_ok),
    .inst_rdata        (inst_rdata),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_wstrb        (data_wstrb),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_addr_ok      (data_addr_ok),
    .data_data_ok      (data_data_ok),
    .data_rdata        (data_rdata),
    .bus_req           (bus_req),
    .bus_wr            (bus_wr),
    .bus_wstrb         (bus_wstrb),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_addr_ok       (bus_addr_ok),
    .bus_data_ok       (bus_data_ok),
    .bus_rdata         (bus_rdata),
    .outstanding_count (outstanding_count),
    .protocol_error    (protocol_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, checks 2 units later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = 4'h0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    // Reset: requests and responses present but all handshakes suppressed.
    inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    tick(); settle();
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
    chk("rst_data_data_ok", {31'b0, data_data_ok}, 32'd0);
    tick(); settle();
    chk("rst_count", {29'b0, outstanding_count}, 32'd0);
    chk("rst_perr", {31'b0, protocol_error}, 32'd0);
    idle_inputs();
    reset = 1'b0;
    tick();

    // Single fetch, first cycle stalled, accepted next cycle.
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    settle();
    chk("f_bus_req", {31'b0, bus_req}, 32'd1);
    chk("f_bus_addr", bus_addr, 32'hBFC00000);
    chk("f_bus_wr", {31'b0, bus_wr}, 32'd0);
    chk("f_no_ok", {31'b0, inst_addr_ok}, 32'd0);
    tick();
    bus_addr_ok = 1'b1;
    settle();
    chk("f_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd1);
    chk("f_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
    tick();
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    settle();
    chk("f_count1", {29'b0, outstanding_count}, 32'd1);
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'h3C080001;
    settle();
    chk("f_inst_data_ok", {31'b0, inst_data_ok}, 32'd1);
    chk("f_inst_rdata", inst_rdata, 32'h3C080001);
    chk("f_data_data_ok", {31'b0, data_data_ok}, 32'd0);
    tick();
    bus_data_ok = 1'b0;
    settle();
    chk("f_count0", {29'b0, outstanding_count}, 32'd0);

    // Contention: data first, fetch next cycle, responses in issue order.
    inst_req = 1'b1; inst_addr = 32'h00001000;
    data_req = 1'b1; data_addr = 32'h00002000; bus_addr_ok = 1'b1;
    settle();
    chk("c_data_wins", {31'b0, data_addr_ok}, 32'd1);
    chk("c_inst_loses", {31'b0, inst_addr_ok}, 32'd0);
    chk("c_addr_data", bus_addr, 32'h00002000);
    tick();
    data_req = 1'b0;
    settle();
    chk("c_inst_next", {31'b0, inst_addr_ok}, 32'd1);
    chk("c_addr_inst", bus_addr, 32'h00001000);
    tick();
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    settle();
    chk("c_count2", {29'b0, outstanding_count}, 32'd2);
    bus_data_ok = 1'b1; bus_rdata = 32'hAAAA0000;
    settle();
    chk("c_resp1_data", {31'b0, data_data_ok}, 32'd1);
    chk("c_resp1_inst", {31'b0, inst_data_ok}, 32'd0);
    chk("c_resp1_rdata", data_rdata, 32'hAAAA0000);
    tick();
    bus_rdata = 32'h5555FFFF;
    settle();
    chk("c_resp2_inst", {31'b0, inst_data_ok}, 32'd1);
    chk("c_resp2_data", {31'b0, data_data_ok}, 32'd0);
    chk("c_resp2_rdata", inst_rdata, 32'h5555FFFF);
    tick();
    bus_data_ok = 1'b0;

    // Starvation: eight data wins, then the fetch is forced through.
    inst_req = 1'b1; inst_addr = 32'h00003000;
    data_req = 1'b1; data_addr = 32'h00004000; bus_addr_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_data_ok = (i > 0);
      settle();
      chk("s_data_grant", {31'b0, data_addr_ok}, 32'd1);
      chk("s_inst_wait", {31'b0, inst_addr_ok}, 32'd0);
      if (i > 0) chk("s_data_resp", {31'b0, data_data_ok}, 32'd1);
      tick();
    end
    bus_data_ok = 1'b1;
    settle();
    chk("s_inst_forced", {31'b0, inst_addr_ok}, 32'd1);
    chk("s_data_held", {31'b0, data_addr_ok}, 32'd0);
    chk("s_addr_inst", bus_addr, 32'h00003000);
    tick();
    settle();
    chk("s_data_again", {31'b0, data_addr_ok}, 32'd1);
    chk("s_inst_resp", {31'b0, inst_data_ok}, 32'd1);
    tick();
    inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0;
    settle();
    chk("s_drain_data", {31'b0, data_data_ok}, 32'd1);
    tick();
    bus_data_ok = 1'b0;
    settle();
    chk("s_count0", {29'b0, outstanding_count}, 32'd0);

    // Lock: stalled fetch keeps the bus while a store arrives.
    inst_req = 1'b1; inst_addr = 32'h00005000;
    settle();
    chk("l_c1_addr", bus_addr, 32'h00005000);
    tick();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h00006000; data_wdata = 32'hDEADBEEF;
    settle();
    chk("l_c2_addr", bus_addr, 32'h00005000);
    chk("l_c2_wr", {31'b0, bus_wr}, 32'd0);
    tick();
    settle();
    chk("l_c3_addr", bus_addr, 32'h00005000);
    tick();
    bus_addr_ok = 1'b1;
    settle();
    chk("l_inst_ok", {31'b0, inst_addr_ok}, 32'd1);
    chk("l_no_data_ok", {31'b0, data_addr_ok}, 32'd0);
    chk("l_c4_addr", bus_addr, 32'h00005000);
    tick();
    inst_req = 1'b0;
    settle();
    chk("l_data_ok", {31'b0, data_addr_ok}, 32'd1);
    chk("l_data_addr", bus_addr, 32'h00006000);
    chk("l_data_wr", {31'b0, bus_wr}, 32'd1);
    chk("l_data_wdata", bus_wdata, 32'hDEADBEEF);
    tick();
    data_req = 1'b0; data_wr = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    settle();
    chk("l_resp_inst", {31'b0, inst_data_ok}, 32'd1);
    tick();
    settle();
    chk("l_resp_store", {31'b0, data_data_ok}, 32'd1);
    tick();
    bus_data_ok = 1'b0;

    // Full: four stores fill the FIFO and block the bus.
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b1100;
    data_addr = 32'h00007000; data_wdata = 32'h12345678; bus_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("u_store_ok", {31'b0, data_addr_ok}, 32'd1);
      chk("u_wstrb", {28'b0, bus_wstrb}, 32'h0000000C);
      tick();
    end
    settle();
    chk("u_count4", {29'b0, outstanding_count}, 32'd4);
    chk("u_bus_req_low", {31'b0, bus_req}, 32'd0);
    chk("u_no_accept", {31'b0, data_addr_ok}, 32'd0);
    tick();
    bus_data_ok = 1'b1;
    settle();
    chk("u_pop_ack", {31'b0, data_data_ok}, 32'd1);
    chk("u_full_pop_req", {31'b0, bus_req}, 32'd0);
    tick();
    bus_data_ok = 1'b0;
    settle();
    chk("u_count3", {29'b0, outstanding_count}, 32'd3);
    chk("u_bus_req_back", {31'b0, bus_req}, 32'd1);
    tick();
    data_req = 1'b0; data_wr = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus_data_ok = 1'b0;
    settle();
    chk("u_drained", {29'b0, outstanding_count}, 32'd0);

    // Stray response after reset: flagged and sticky.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'h0BADF00D;
    settle();
    chk("e_no_data_ok", {31'b0, data_data_ok}, 32'd0);
    chk("e_no_inst_ok", {31'b0, inst_data_ok}, 32'd0);
    chk("e_perr_pre", {31'b0, protocol_error}, 32'd0);
    tick();
    bus_data_ok = 1'b0;
    settle();
    chk("e_perr_set", {31'b0, protocol_error}, 32'd1);
    tick(); tick(); tick();
    settle();
    chk("e_perr_sticky", {31'b0, protocol_error}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("e_perr_cleared", {31'b0, protocol_error}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
